// File: rtl/dcm_lock_sequencer.sv
// dcm_lock_sequencer: retrying DCM reset/lock sequencer with ordered MAC/HUFF domain reset release.
// Optional macro DCM_LOCK_RECOVERY_EN: lock loss in READY re-sequences instead of latching FAIL.
module dcm_lock_sequencer #(
  parameter int          RST_PULSE_CYCLES = 16,
  parameter int          LOCK_TIMEOUT     = 65535,
  parameter int          SETTLE_CYCLES    = 256,
  parameter int          RELEASE_GAP      = 8,
  parameter logic [3:0]  MAX_RETRIES      = 4'd7
) (
  input  logic       MASTER_CLOCK_O,
  input  logic       RESETN_I,
  input  logic       MAC_LOCKED_I,
  input  logic       HUFF_LOCKED_I,
  output logic       DCM_RESET_O,
  output logic       CLOCK_READY_O,
  output logic       MAC_RESETN_O,
  output logic       HUFF_RESETN_O,
  output logic       LOCK_FAIL_O,
  output logic [3:0] RETRY_COUNT_O
);
  typedef enum logic [2:0] {RESET_PULSE, WAIT_LOCK, SETTLE, READY, FAIL} state_t;
  localparam logic [15:0] PULSE_LAST   = 16'(RST_PULSE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST     = 16'(RELEASE_GAP - 1);
  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [3:0]  retry_n;
  logic [1:0]  mac_sync, huff_sync;
  logic        both_locked, retry_req, huff_n;
  assign both_locked = mac_sync[1] & huff_sync[1];
  // two-flop synchronizers for the asynchronous LOCKED inputs
  always_ff @(posedge MASTER_CLOCK_O or negedge RESETN_I)
    if (!RESETN_I) begin
      mac_sync  <= 2'b00;
      huff_sync <= 2'b00;
    end else begin
      mac_sync  <= {mac_sync[0], MAC_LOCKED_I};
      huff_sync <= {huff_sync[0], HUFF_LOCKED_I};
    end
  // next state, phase counter and retry bookkeeping
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 16'd1;
    retry_n   = RETRY_COUNT_O;
    retry_req = 1'b0;
    unique case (state)
      RESET_PULSE: if (cnt == PULSE_LAST) begin
        state_n = WAIT_LOCK;
        cnt_n   = 16'd0;
      end
      WAIT_LOCK: if (both_locked) begin
        state_n = SETTLE;
        cnt_n   = 16'd0;
      end else if (cnt == TIMEOUT_LAST) retry_req = 1'b1;
      SETTLE: if (!both_locked) retry_req = 1'b1;
      else if (cnt == SETTLE_LAST) begin
        state_n = READY;
        cnt_n   = 16'd0;
        retry_n = 4'd0;
      end
`ifdef DCM_LOCK_RECOVERY_EN
      READY: if (!both_locked) retry_req = 1'b1;
      else if (cnt == GAP_LAST) cnt_n = cnt;
`else
      READY: if (!both_locked) state_n = FAIL;
      else if (cnt == GAP_LAST) cnt_n = cnt;
`endif
      FAIL: cnt_n = cnt;
      default: state_n = FAIL;
    endcase
    if (retry_req) begin
      state_n = (RETRY_COUNT_O == MAX_RETRIES) ? FAIL : RESET_PULSE;
      cnt_n   = 16'd0;
      retry_n = (RETRY_COUNT_O == MAX_RETRIES || RETRY_COUNT_O == 4'hF) ? RETRY_COUNT_O : RETRY_COUNT_O + 4'd1;
    end
    huff_n = (state_n == READY) && (HUFF_RESETN_O || (state == READY && cnt == GAP_LAST));
  end
  // state register with outputs registered from the next state
  always_ff @(posedge MASTER_CLOCK_O or negedge RESETN_I)
    if (!RESETN_I) begin
      state         <= RESET_PULSE;
      cnt           <= 16'd0;
      DCM_RESET_O   <= 1'b1;
      CLOCK_READY_O <= 1'b0;
      MAC_RESETN_O  <= 1'b0;
      HUFF_RESETN_O <= 1'b0;
      LOCK_FAIL_O   <= 1'b0;
      RETRY_COUNT_O <= 4'd0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      DCM_RESET_O   <= state_n == RESET_PULSE || state_n == FAIL;
      CLOCK_READY_O <= state_n == READY;
      MAC_RESETN_O  <= state_n == READY;
      HUFF_RESETN_O <= huff_n;
      LOCK_FAIL_O   <= state_n == FAIL;
      RETRY_COUNT_O <= retry_n;
    end
endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// tb_dcm_lock_sequencer: directed scenarios checked against a timestamp-based model plus literal cycle pins.
module tb_dcm_lock_sequencer;
  localparam int P = 4, T = 20, S = 8, G = 3;
  localparam logic [3:0] M = 4'd2;
  localparam int PH_PULSE = 0, PH_WAIT = 1, PH_SETTLE = 2, PH_READY = 3, PH_FAIL = 4;
  logic clk = 1'b0, rstn = 1'b0, mac_l = 1'b0, huff_l = 1'b0;
  logic dcm_rst, clk_rdy, mac_rn, huff_rn, lock_fail;
  logic [3:0] retry_cnt;
  int vectors = 0, miscompares = 0;
  int c = 0;
  int mcyc = 0, phase = PH_PULSE, pstart = 1, m_retry = 0, e;
  bit d1 = 0, d2 = 0, bl, rt;

  always #5 clk = ~clk;

  dcm_lock_sequencer #(.RST_PULSE_CYCLES(P), .LOCK_TIMEOUT(T), .SETTLE_CYCLES(S),
                       .RELEASE_GAP(G), .MAX_RETRIES(M)) dut (
    .MASTER_CLOCK_O(clk), .RESETN_I(rstn), .MAC_LOCKED_I(mac_l), .HUFF_LOCKED_I(huff_l),
    .DCM_RESET_O(dcm_rst), .CLOCK_READY_O(clk_rdy), .MAC_RESETN_O(mac_rn),
    .HUFF_RESETN_O(huff_rn), .LOCK_FAIL_O(lock_fail), .RETRY_COUNT_O(retry_cnt));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @t=%0t cycle %0d: got %0d expected %0d", name, $time, c, act, exp);
    end
  endtask

  // model: phases tracked by start timestamp; both_locked is the raw AND delayed two edges
  initial forever begin
    @(posedge clk);
    mcyc++;
    if (!rstn) begin
      phase = PH_PULSE; pstart = mcyc + 1; m_retry = 0; d1 = 0; d2 = 0;
    end else begin
      bl = d2; d2 = d1; d1 = mac_l & huff_l;
      e = mcyc - pstart; rt = 0;
      case (phase)
        PH_PULSE:  if (e == P - 1) begin phase = PH_WAIT; pstart = mcyc + 1; end
        PH_WAIT:   if (bl) begin phase = PH_SETTLE; pstart = mcyc + 1; end else if (e == T - 1) rt = 1;
        PH_SETTLE: if (!bl) rt = 1; else if (e == S - 1) begin phase = PH_READY; pstart = mcyc + 1; m_retry = 0; end
`ifdef DCM_LOCK_RECOVERY_EN
        PH_READY:  if (!bl) rt = 1;
`else
        PH_READY:  if (!bl) begin phase = PH_FAIL; pstart = mcyc + 1; end
`endif
        default: ;
      endcase
      if (rt) begin
        if (m_retry == int'(M)) phase = PH_FAIL;
        else begin m_retry++; phase = PH_PULSE; end
        pstart = mcyc + 1;
      end
    end
    #1;
    check("m_dcm_reset", dcm_rst, phase == PH_PULSE || phase == PH_FAIL);
    check("m_clock_ready", clk_rdy, phase == PH_READY);
    check("m_mac_resetn", mac_rn, phase == PH_READY);
    check("m_huff_resetn", huff_rn, phase == PH_READY && (mcyc + 1 - pstart) >= G);
    check("m_lock_fail", lock_fail, phase == PH_FAIL);
    check("m_retry_count", retry_cnt, m_retry);
  end

  task automatic step_to(input int t);
    while (c < t) begin @(negedge clk); c++; end
  endtask

  task automatic reset_seq(input logic m, input logic h);
    @(negedge clk);
    rstn = 1'b0; mac_l = m; huff_l = h;
    #1;
    check("rst_dcm_reset", dcm_rst, 1);
    check("rst_clock_ready", clk_rdy, 0);
    check("rst_mac_resetn", mac_rn, 0);
    check("rst_huff_resetn", huff_rn, 0);
    check("rst_lock_fail", lock_fail, 0);
    check("rst_retry_count", retry_cnt, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1; c = 0;
  endtask

  initial begin
    // clean startup, then a one-cycle HUFF drop while READY
    reset_seq(0, 0);
    for (int k = 0; k < P; k++) begin step_to(k); check("pulse_high", dcm_rst, 1); end
    step_to(4);  check("pulse_end", dcm_rst, 0);
    step_to(6);  mac_l = 1; huff_l = 1;
    step_to(16); check("ready_early", clk_rdy, 0);
    step_to(17); check("ready_rise", clk_rdy, 1); check("mac_rise", mac_rn, 1); check("huff_held", huff_rn, 0);
    step_to(19); check("huff_gap", huff_rn, 0);
    step_to(20); check("huff_rise", huff_rn, 1);
    step_to(30); huff_l = 0;
    step_to(31); huff_l = 1;
    step_to(32); check("drop_lat_ready", clk_rdy, 1);
    step_to(33); check("drop_ready", clk_rdy, 0); check("drop_mac", mac_rn, 0); check("drop_huff", huff_rn, 0);
`ifdef DCM_LOCK_RECOVERY_EN
    check("recov_pulse", dcm_rst, 1); check("recov_retry", retry_cnt, 1);
    step_to(45); check("recov_not_ready", clk_rdy, 0); check("recov_retry_hold", retry_cnt, 1);
    step_to(46); check("recov_ready", clk_rdy, 1); check("recov_retry_clr", retry_cnt, 0);
    step_to(49); check("recov_huff", huff_rn, 1);
`else
    check("loss_fail", lock_fail, 1); check("loss_dcm", dcm_rst, 1);
    step_to(46); check("loss_sticky", lock_fail, 1); check("loss_no_ready", clk_rdy, 0);
`endif
    // HUFF never locks: two retries then FAIL
    reset_seq(1, 0);
    step_to(23); check("to1_before", retry_cnt, 0); check("to1_dcm_low", dcm_rst, 0);
    step_to(24); check("to1_retry", retry_cnt, 1); check("to1_pulse", dcm_rst, 1);
    step_to(27); check("to1_pulse_last", dcm_rst, 1);
    step_to(28); check("to1_pulse_end", dcm_rst, 0);
    step_to(48); check("to2_retry", retry_cnt, 2); check("to2_pulse", dcm_rst, 1);
    step_to(71); check("to3_before", lock_fail, 0);
    step_to(72); check("to3_fail", lock_fail, 1); check("to3_dcm", dcm_rst, 1); check("to3_retry", retry_cnt, 2);
    step_to(73); huff_l = 1;
    step_to(90); check("fail_sticky", lock_fail, 1); check("fail_no_ready", clk_rdy, 0);
    // reset out of FAIL; locks present during the pulse; MAC glitch at settle count 5
    reset_seq(1, 1);
    step_to(3);  check("locks_ignored", dcm_rst, 1);
    step_to(8);  mac_l = 0;
    step_to(9);  mac_l = 1;
    step_to(10); check("glitch_pre", retry_cnt, 0); check("glitch_no_ready", clk_rdy, 0);
    step_to(11); check("glitch_retry", retry_cnt, 1); check("glitch_pulse", dcm_rst, 1);
    step_to(23); check("glitch_ready_early", clk_rdy, 0);
    step_to(24); check("glitch_ready", clk_rdy, 1); check("glitch_retry_clr", retry_cnt, 0);
    // drop on the very cycle the settle count completes
    reset_seq(1, 1);
    step_to(10); mac_l = 0;
    step_to(11); mac_l = 1;
    step_to(12); check("edge_pre", clk_rdy, 0);
    step_to(13); check("edge_no_ready", clk_rdy, 0); check("edge_retry", retry_cnt, 1); check("edge_pulse", dcm_rst, 1);
    step_to(30);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
